// File: rtl/ste_lmc_pkg.sv
// Shared definitions for the LMC1992 volume/tone controller model.
// Holds Microwire command codes, the device address, register range limits,
// reset defaults, mix-mode encodings, the datapath FSM state type and small
// helpers used by the control and datapath logic.
package ste_lmc_pkg;

    // Microwire command codes, frame[8:6]
    localparam logic [2:0] CMD_MIX    = 3'd0;
    localparam logic [2:0] CMD_BASS   = 3'd1;
    localparam logic [2:0] CMD_TREBLE = 3'd2;
    localparam logic [2:0] CMD_MASTER = 3'd3;
    localparam logic [2:0] CMD_RIGHT  = 3'd4;
    localparam logic [2:0] CMD_LEFT   = 3'd5;

    // LMC1992 device address, frame[10:9]
    localparam logic [1:0] DEV_ADDR = 2'b10;

    // Register range limits (2 dB steps)
    localparam logic [5:0] TONE_MAX   = 6'd12;
    localparam logic [5:0] MASTER_MAX = 6'd40;
    localparam logic [5:0] SIDE_MAX   = 6'd20;

    // Mix-mode encodings
    localparam logic [1:0] MIX_YM_M12   = 2'b00;
    localparam logic [1:0] MIX_YM_0DB   = 2'b01;
    localparam logic [1:0] MIX_DMA_ONLY = 2'b10;

    // Reset defaults
    localparam logic [5:0] MASTER_RST = 6'd40;
    localparam logic [4:0] SIDE_RST   = 5'd20;
    localparam logic [3:0] TONE_RST   = 4'd6;
    localparam logic [1:0] MIX_RST    = MIX_YM_0DB;

    typedef enum logic [1:0] {
        StIdle,
        StMix,
        StMulL,
        StMulR
    } dp_state_e;

    function automatic logic [5:0] sat_val(input logic [5:0] val, input logic [5:0] lim);
        return (val > lim) ? lim : val;
    endfunction

    // Offset-binary inputs to a signed sum, then scaled up by 2^7 into 16 bits.
    function automatic logic signed [15:0] mix_sample(input logic [7:0] dma,
                                                      input logic [7:0] ym,
                                                      input logic [1:0] mode);
        logic signed [9:0] d;
        logic signed [9:0] y;
        logic signed [9:0] sum;
        // x - 128 on an 8-bit offset-binary value is just an MSB flip
        d = {{3{~dma[7]}}, dma[6:0]};
        y = {{3{~ym[7]}}, ym[6:0]};
        case (mode)
            MIX_YM_M12:   sum = d + (y >>> 2);
            MIX_YM_0DB:   sum = d + y;
            MIX_DMA_ONLY: sum = d;
            default:      sum = d;
        endcase
        return 16'(sum) <<< 7;
    endfunction

endpackage

// File: rtl/ste_lmc_gain_rom.sv
// Attenuation-to-gain table for the LMC1992 model.
// Ports:
//   att  in  6       attenuation in 2 dB units (0..60)
//   gain out GAIN_W  round(32767 * 10^(-att/10)), Q1.15; 0 for att > 60
module ste_lmc_gain_rom #(
    parameter int unsigned GAIN_W = 16
) (
    input  logic [5:0]        att,
    output logic [GAIN_W-1:0] gain
);

    // Entries 49..60 round to zero and fall into the default branch.
    always_comb begin
        gain = '0;
        case (att)
            6'd0:  gain = GAIN_W'(32767);
            6'd1:  gain = GAIN_W'(26028);
            6'd2:  gain = GAIN_W'(20675);
            6'd3:  gain = GAIN_W'(16422);
            6'd4:  gain = GAIN_W'(13045);
            6'd5:  gain = GAIN_W'(10362);
            6'd6:  gain = GAIN_W'(8231);
            6'd7:  gain = GAIN_W'(6538);
            6'd8:  gain = GAIN_W'(5193);
            6'd9:  gain = GAIN_W'(4125);
            6'd10: gain = GAIN_W'(3277);
            6'd11: gain = GAIN_W'(2603);
            6'd12: gain = GAIN_W'(2067);
            6'd13: gain = GAIN_W'(1642);
            6'd14: gain = GAIN_W'(1304);
            6'd15: gain = GAIN_W'(1036);
            6'd16: gain = GAIN_W'(823);
            6'd17: gain = GAIN_W'(654);
            6'd18: gain = GAIN_W'(519);
            6'd19: gain = GAIN_W'(413);
            6'd20: gain = GAIN_W'(328);
            6'd21: gain = GAIN_W'(260);
            6'd22: gain = GAIN_W'(207);
            6'd23: gain = GAIN_W'(164);
            6'd24: gain = GAIN_W'(130);
            6'd25: gain = GAIN_W'(104);
            6'd26: gain = GAIN_W'(82);
            6'd27: gain = GAIN_W'(65);
            6'd28: gain = GAIN_W'(52);
            6'd29: gain = GAIN_W'(41);
            6'd30: gain = GAIN_W'(33);
            6'd31: gain = GAIN_W'(26);
            6'd32: gain = GAIN_W'(21);
            6'd33: gain = GAIN_W'(16);
            6'd34: gain = GAIN_W'(13);
            6'd35: gain = GAIN_W'(10);
            6'd36: gain = GAIN_W'(8);
            6'd37: gain = GAIN_W'(7);
            6'd38: gain = GAIN_W'(5);
            6'd39: gain = GAIN_W'(4);
            6'd40: gain = GAIN_W'(3);
            6'd41: gain = GAIN_W'(3);
            6'd42: gain = GAIN_W'(2);
            6'd43: gain = GAIN_W'(2);
            6'd44: gain = GAIN_W'(1);
            6'd45: gain = GAIN_W'(1);
            6'd46: gain = GAIN_W'(1);
            6'd47: gain = GAIN_W'(1);
            6'd48: gain = GAIN_W'(1);
            default: gain = '0;
        endcase
    end

endmodule

// File: rtl/ste_lmc1992.sv
// LMC1992 volume/tone controller model downstream of the STE DMA sound block.
// Receives Microwire frames into control registers, mixes DMA audio with the
// YM2149 output and applies master + per-side attenuation through one shared
// multiplier.
// Ports:
//   clk, reset                  32 MHz clock, synchronous active-high reset
//   mw_stb/mw_mask/mw_data      Microwire bit strobe, mask and serial data
//   mw_done                     end-of-transfer pulse
//   sample_en                   50 kHz sample request pulse
//   dma_l/dma_r/ym_in           offset-binary audio inputs
//   out_l/out_r/out_valid       signed stereo result and its update pulse
//   mw_err                      pulse on a rejected Microwire frame
// Build option STE_LMC_DEBUG_EN adds dbg_regs (register snapshot) and
// dbg_err_cnt (saturating rejected-frame counter).
module ste_lmc1992
    import ste_lmc_pkg::*;
#(
    parameter int unsigned GAIN_W = 16,
    parameter int unsigned OUT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mw_stb,
    input  logic             mw_mask,
    input  logic             mw_data,
    input  logic             mw_done,
    input  logic             sample_en,
    input  logic [7:0]       dma_l,
    input  logic [7:0]       dma_r,
    input  logic [7:0]       ym_in,
    output logic [OUT_W-1:0] out_l,
    output logic [OUT_W-1:0] out_r,
    output logic             out_valid,
    output logic             mw_err
`ifdef STE_LMC_DEBUG_EN
    ,
    output logic [31:0]      dbg_regs,
    output logic [7:0]       dbg_err_cnt
`endif
);

    localparam int unsigned PROD_W = GAIN_W + 17;

    // ---------------- Microwire receive ----------------
    logic [10:0] sr, sr_nxt;
    logic [3:0]  bit_cnt, cnt_nxt;
    logic        frame_ok;

    logic [5:0] master;
    logic [4:0] left, right;
    logic [3:0] bass, treble;
    logic [1:0] mix;

    // A bit strobed in the same cycle as mw_done is part of the evaluated frame.
    always_comb begin
        sr_nxt  = sr;
        cnt_nxt = bit_cnt;
        if (mw_stb && mw_mask) begin
            sr_nxt = {sr[9:0], mw_data};
            if (bit_cnt != 4'd15) begin
                cnt_nxt = bit_cnt + 4'd1;
            end
        end
    end

    assign frame_ok = (cnt_nxt == 4'd11) && (sr_nxt[10:9] == DEV_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            sr      <= '0;
            bit_cnt <= '0;
            mw_err  <= 1'b0;
            master  <= MASTER_RST;
            left    <= SIDE_RST;
            right   <= SIDE_RST;
            bass    <= TONE_RST;
            treble  <= TONE_RST;
            mix     <= MIX_RST;
        end else begin
            mw_err <= 1'b0;
            if (mw_done) begin
                sr      <= '0;
                bit_cnt <= '0;
                if (frame_ok) begin
                    case (sr_nxt[8:6])
                        CMD_MIX:    mix    <= sr_nxt[1:0];
                        CMD_BASS:   bass   <= 4'(sat_val(sr_nxt[5:0], TONE_MAX));
                        CMD_TREBLE: treble <= 4'(sat_val(sr_nxt[5:0], TONE_MAX));
                        CMD_MASTER: master <= sat_val(sr_nxt[5:0], MASTER_MAX);
                        CMD_RIGHT:  right  <= 5'(sat_val(sr_nxt[5:0], SIDE_MAX));
                        CMD_LEFT:   left   <= 5'(sat_val(sr_nxt[5:0], SIDE_MAX));
                        default: ;  // unused command codes are accepted silently
                    endcase
                end else begin
                    mw_err <= 1'b1;
                end
            end else begin
                sr      <= sr_nxt;
                bit_cnt <= cnt_nxt;
            end
        end
    end

    // ---------------- Sample datapath ----------------
    dp_state_e         state;
    logic [7:0]        dma_l_q, dma_r_q, ym_q;
    logic [1:0]        mix_q;
    logic [5:0]        att_l, att_r;
    logic signed [15:0] s_l, s_r;

    logic signed [15:0]       mul_a;
    logic [5:0]               mul_att;
    logic [GAIN_W-1:0]        gain;
    logic signed [PROD_W-1:0] prod;
    logic [OUT_W-1:0]         mul_res;

    // One multiplier serves both channels; MUL_R selects the right-hand operands.
    always_comb begin
        mul_a   = (state == StMulR) ? s_r : s_l;
        mul_att = (state == StMulR) ? att_r : att_l;
        prod    = PROD_W'(mul_a) * PROD_W'(signed'({1'b0, gain}));
        mul_res = OUT_W'(prod >>> 15);
    end

    ste_lmc_gain_rom #(
        .GAIN_W (GAIN_W)
    ) u_gain_rom (
        .att  (mul_att),
        .gain (gain)
    );

    // Everything a sample needs is captured in IDLE, so later register writes
    // cannot disturb a sample already in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            dma_l_q   <= '0;
            dma_r_q   <= '0;
            ym_q      <= '0;
            mix_q     <= MIX_RST;
            att_l     <= '0;
            att_r     <= '0;
            s_l       <= '0;
            s_r       <= '0;
            out_l     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                StIdle: begin
                    if (sample_en) begin
                        dma_l_q <= dma_l;
                        dma_r_q <= dma_r;
                        ym_q    <= ym_in;
                        mix_q   <= mix;
                        att_l   <= (MASTER_MAX - master) + (SIDE_MAX - {1'b0, left});
                        att_r   <= (MASTER_MAX - master) + (SIDE_MAX - {1'b0, right});
                        state   <= StMix;
                    end
                end
                StMix: begin
                    s_l   <= mix_sample(dma_l_q, ym_q, mix_q);
                    s_r   <= mix_sample(dma_r_q, ym_q, mix_q);
                    state <= StMulL;
                end
                StMulL: begin
                    out_l <= mul_res;
                    state <= StMulR;
                end
                StMulR: begin
                    out_r     <= mul_res;
                    out_valid <= 1'b1;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef STE_LMC_DEBUG_EN
    assign dbg_regs = {mix, bass, treble, master, left, right, 6'd0};

    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_err_cnt <= '0;
        end else if (mw_done && !frame_ok && (dbg_err_cnt != 8'hFF)) begin
            dbg_err_cnt <= dbg_err_cnt + 8'd1;
        end
    end
`else
    // Tone settings are write-only state in this build.
    logic unused_tone;
    assign unused_tone = ^{bass, treble};
`endif

endmodule
